// File: rtl/instruction_encoder_if.sv
// Request/response bundle for the MIPS instruction encoder.
// master drives requests and consumes words; slave is the encoder.
interface instruction_encoder_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;
    logic [15:0] encoded_count;
    logic [7:0]  error_count;

    modport master (
        output flush, in_valid, in_kind, in_rs, in_rt, in_rd,
        output in_shamt, in_funct, in_imm, out_ready,
        input  in_ready, out_valid, out_word, out_err,
        input  encoded_count, error_count
    );

    modport slave (
        input  flush, in_valid, in_kind, in_rs, in_rt, in_rd,
        input  in_shamt, in_funct, in_imm, out_ready,
        output in_ready, out_valid, out_word, out_err,
        output encoded_count, error_count
    );
endinterface

// File: rtl/instruction_encoder.sv
// Buffered MIPS instruction encoder: field requests in, packed words out.
// Encoding is combinational ahead of a small circular output FIFO.
module instruction_encoder #(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    instruction_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] A_ONE = 1;
    localparam logic [AW:0]   C_ONE = 1;
    localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);

    logic [5:0]  w_op;
    logic        w_rsv;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_word;
    logic        w_push;
    logic        w_pop;

    logic [32:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_enc_cnt;
    logic [7:0]    r_err_cnt;

    // Map kind to opcode, apply forced fields and pack the word.
    always_comb begin
        w_op   = 6'h00;
        w_rsv  = 1'b0;
        w_rs   = bus.in_rs;
        w_rt   = bus.in_rt;
        w_word = 32'h0;
        case (bus.in_kind)
            5'd0:    w_op = 6'h02;
            5'd1:    w_op = 6'h03;
            5'd2:    w_op = 6'h04;
            5'd3:    w_op = 6'h05;
            5'd4:    w_op = 6'h06;
            5'd5:    w_op = 6'h07;
            5'd6:    w_op = 6'h08;
            5'd7:    w_op = 6'h09;
            5'd8:    w_op = 6'h0A;
            5'd9:    w_op = 6'h0B;
            5'd10:   w_op = 6'h0C;
            5'd11:   w_op = 6'h0D;
            5'd12:   w_op = 6'h0E;
            5'd13:   w_op = 6'h0F;
            5'd14:   w_op = 6'h20;
            5'd15:   w_op = 6'h21;
            5'd16:   w_op = 6'h23;
            5'd17:   w_op = 6'h2B;
            5'd18:   w_op = 6'h00;
            default: w_rsv = 1'b1;
        endcase
        if (bus.in_kind == 5'd4 || bus.in_kind == 5'd5)
            w_rt = 5'd0;
        if (bus.in_kind == 5'd13)
            w_rs = 5'd0;
        if (w_rsv)
            w_word = 32'h0;
        else if (bus.in_kind <= 5'd1)
            w_word = {w_op, bus.in_imm};
        else if (bus.in_kind == 5'd18)
            w_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd,
                      bus.in_shamt, bus.in_funct};
        else
            w_word = {w_op, w_rs, w_rt, bus.in_imm[15:0]};
    end

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    // FIFO storage, pointers and occupancy; flush empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {w_rsv, w_word};
                r_wptr        <= r_wptr + A_ONE;
            end
            if (w_pop)
                r_rptr <= r_rptr + A_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Encoded count wraps; error count saturates; flush has no effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_push) begin
            if (!w_rsv)
                r_enc_cnt <= r_enc_cnt + 16'd1;
            else if (r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.in_ready      = (r_count != FULL);
    assign bus.out_valid     = (r_count != '0);
    assign bus.out_err       = r_mem[r_rptr][32];
    assign bus.out_word      = r_mem[r_rptr][31:0];
    assign bus.encoded_count = r_enc_cnt;
    assign bus.error_count   = r_err_cnt;
endmodule
